atomrvcore_dccm_lsu: RTL

Next-generation data closely-coupled memory and load/store stage for the atomRVCORE pipeline, sitting between execute and writeback.
- Adds byte-lane stores, sized loads with sign/zero extension and misalignment detection.
- Adds a pipeline stall input and parametrised depth and width.
- Registers the writeback controls (RWR_EN, RD, result) and muxes the formatted load data onto the writeback bus one cycle after issue.

---
 rtl/atomrvcore_dccm_lsu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/atomrvcore_dccm_lsu.sv
// -----------------------------------------------------------------------------
// atomrvcore_dccm_lsu
//
// Data closely-coupled memory plus the load/store stage of the atomRVCORE
// pipeline. It sits between execute and writeback. It performs byte-lane
// stores and sized loads with sign or zero extension. It flags misaligned or
// illegal accesses, and it registers the writeback controls one cycle after
// issue.
//
// Parameters
//   DATAWIDTH        data/address width (must be 32: four byte lanes)
//   ADDRESS_BUS      log2 of memory depth in words
//   REG_ADRESS_WIDTH destination register index width
//
// Ports
//   clk_i, rst_ni    clock (rising edge), asynchronous active-low reset
//   valid_i          instruction present in this stage
//   stall_i          hold stage: no memory write, all registers hold
//   DWR_EN_i         store request
//   DR_EN_i          load request
//   size_i           00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i       zero-extend loads (LBU/LHU)
//   address_i        byte address (word index wraps modulo depth)
//   DT_i             store data, right-aligned
//   RD_i, RWR_EN_i   destination register and write enable from execute
//   result_i         ALU result for non-load instructions
//   valid_o          stage output valid
//   RWR_EN_o, RD_o   register write enable / destination to writeback
//   WR_o             writeback value (formatted load data or registered result)
//   misalign_o       misaligned or illegal access fault
// -----------------------------------------------------------------------------
module atomrvcore_dccm_lsu #(
    parameter int DATAWIDTH        = 32,
    parameter int ADDRESS_BUS      = 10,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    input  logic                        stall_i,
    input  logic                        DWR_EN_i,
    input  logic                        DR_EN_i,
    input  logic [1:0]                  size_i,
    input  logic                        unsigned_i,
    input  logic [DATAWIDTH-1:0]        address_i,
    input  logic [DATAWIDTH-1:0]        DT_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic [DATAWIDTH-1:0]        result_i,
    output logic                        valid_o,
    output logic                        RWR_EN_o,
    output logic [REG_ADRESS_WIDTH-1:0] RD_o,
    output logic [DATAWIDTH-1:0]        WR_o,
    output logic                        misalign_o
);

    localparam int DEPTH = 1 << ADDRESS_BUS;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic [ADDRESS_BUS-1:0] index;
    logic [1:0]             offset;
    logic                   fire;
    logic                   access;
    logic                   mis;
    logic                   store_en;
    logic                   read_en;
    logic [3:0]             byte_en;
    logic [DATAWIDTH-1:0]   wdata;

    // Address bits above the word index are deliberately ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, address_i[DATAWIDTH-1:ADDRESS_BUS+2]};

    assign index  = address_i[ADDRESS_BUS+1:2];
    assign offset = address_i[1:0];
    assign fire   = valid_i & ~stall_i;
    assign access = DWR_EN_i | DR_EN_i;

    // Alignment check, lane enables and lane-replicated store data.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mis     = 1'b0;
        byte_en = 4'b0000;
        wdata   = DT_i;
        case (size_i)
            SZ_BYTE: begin
                byte_en = 4'b0001 << offset;
                wdata   = {4{DT_i[7:0]}};
            end
            SZ_HALF: begin
                mis     = offset[0];
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{DT_i[15:0]}};
            end
            SZ_WORD: begin
                mis     = (offset != 2'b00);
                byte_en = 4'b1111;
            end
            default: begin
                mis     = 1'b1;
            end
        endcase
        // Alignment only matters for an actual memory access; ALU
        // instructions pass through regardless of size/address contents.
        mis = mis & access;
    end

    // A combined store+load performs the store only; the load is dropped.
    assign store_en = fire & DWR_EN_i & ~mis;
    assign read_en  = fire & DR_EN_i & ~DWR_EN_i & ~mis;

    // NOTE: the memory array is intentionally not reset; only the stage
    // registers below are cleared, so the array can map onto RAM macros.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) begin
                    mem[index][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    // Stage registers.
    logic [DATAWIDTH-1:0] rdata_q;
    logic [DATAWIDTH-1:0] result_q;
    logic                 load_q;
    logic [1:0]           offset_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            RWR_EN_o   <= 1'b0;
            misalign_o <= 1'b0;
            RD_o       <= '0;
            result_q   <= '0;
            load_q     <= 1'b0;
            rdata_q    <= '0;
            offset_q   <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            RD_o       <= RD_i;
            RWR_EN_o   <= valid_i & RWR_EN_i & ~mis;
            misalign_o <= valid_i & mis;
            result_q   <= result_i;
            load_q     <= read_en;
            if (read_en) begin
                // Reads the array before this edge's store lands; a load
                // in the following cycle therefore sees the new data.
                rdata_q    <= mem[index];
                offset_q   <= offset;
                size_q     <= size_i;
                unsigned_q <= unsigned_i;
            end
        end
    end

    // Load formatting from the registered word.
    logic [DATAWIDTH-1:0] shifted;
    logic [DATAWIDTH-1:0] load_data;

    assign shifted = rdata_q >> {offset_q, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size_q)
            SZ_BYTE: load_data = {{(DATAWIDTH-8){~unsigned_q & shifted[7]}},
                                  shifted[7:0]};
            SZ_HALF: load_data = {{(DATAWIDTH-16){~unsigned_q & shifted[15]}},
                                  shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign WR_o = load_q ? load_data : result_q;

endmodule
